dac_spi_monitor: RTL
====================

# dac_spi_monitor

Passive receiver for the VCXO-trim DAC serial link. It oversamples the `sclk`/`mosi`/`sync_n` lines driven by the DAC writer in the reference-discipline loop and deserializes each 24-bit frame. It presents the decoded DAC word to status registers and to loopback checking, and counts good and bad frames. It sits beside the DAC pins in the clocking/reference block and never drives the bus.

## Interface
Parameters:
- `DEVICE`, "E200": "E310V2" selects the AD5662 framing, where `hdr[1:0]` is the power-down field and any nonzero value raises `pd_err`. Any other value selects LTC2630 framing, where `hdr[7:4]` is the command and `hdr[3:0]` is the address.
- `SAMPLE_RISE`, 1: 1 samples `mosi` on the `sclk` rising edge (LTC2630). 0 samples on the falling edge; use 0 when `DEVICE`="E310V2".
- `TIMEOUT`, 4095: maximum number of `clk` cycles `sync_n` may stay low before the frame is aborted.

Ports:
- `clk` input 1: block clock, must be at least 4× the `sclk` frequency.
- `reset_n` input 1: synchronous, active-low reset.
- `sclk` input 1: asynchronous, the DAC serial clock.
- `mosi` input 1: asynchronous, DAC serial data, MSB first.
- `sync_n` input 1: asynchronous, active-low frame enable.
- `dat` output 16: frame bits [15:0] of the last good frame.
- `hdr` output 8: frame bits [23:16] of the last good frame.
- `valid` output 1: one-cycle pulse when `dat`/`hdr` update.
- `err_len` output 1: one-cycle pulse when a frame closes with fewer than 24 bits.
- `err_ovr` output 1: one-cycle pulse on the 25th sample edge inside a frame.
- `err_tmo` output 1: one-cycle pulse on timeout.
- `pd_err` output 1: level, valid for E310V2 only, updated with `valid`.
- `busy` output 1: high while a frame is open.
- `frame_cnt` output 16: count of good frames, wraps.
- `err_cnt` output 8: count of error pulses, saturates at 255.

## Operation
- Each of the three inputs passes through a 2-flop synchronizer plus one history flop (s1, s2, s3). Edges are detected on s2/s3.
- Sample edge: `SAMPLE_RISE` ? (s2 & ~s3) : (~s2 & s3) on `sclk`.

State machine:
- ARM: wait for `sync_n` high, then go to IDLE. This prevents joining a frame mid-stream after reset.
- IDLE: on a `sync_n` falling edge, clear the shift register, clear `bitcnt` (5-bit) and the timeout counter, then go to SHIFT.
- SHIFT: on each sample edge, `sr <= {sr[22:0], mosi_s2}` and `bitcnt` increments.
  - A sample edge with `bitcnt`==24 pulses `err_ovr` and goes to ARM.
  - A `sync_n` rising edge with `bitcnt`==24 loads `{hdr,dat}` from `sr`, pulses `valid`, increments `frame_cnt`, and returns to IDLE.
  - A `sync_n` rising edge with `bitcnt`<24 pulses `err_len`, leaves the outputs held, and returns to IDLE.
  - The timeout counter increments every cycle. On reaching `TIMEOUT` it pulses `err_tmo` and goes to ARM.
- Simultaneous sample edge and `sync_n` rise in one cycle: the bit is shifted in and counted first, and the length check uses the updated count.
- `err_cnt` increments once per `err_*` pulse and saturates at 255.
- `busy` is high in SHIFT only.
- A `sync_n` falling edge seen in SHIFT cannot occur; if it does, it is ignored.

## Timing
- Reset (`reset_n` low at a `clk` edge):
  - All outputs go to 0, `pd_err` to 0, and the state to ARM.
  - The synchronizer flops reset to 1 for `sync_n` and to 0 for `sclk`/`mosi`.
  - Reset mid-frame discards the frame with no error pulse. If `sync_n` is still low, the block stays in ARM until it rises.
- Input-to-detect latency: an input transition first captured by s1 at edge k is acted on at edge k+2. `valid`, `dat` and `frame_cnt` all change at edge k+2, coincident.
- `mosi` must be stable for at least 2 `clk` cycles around the sample edge. This is guaranteed by `clk` ≥ 4×`sclk`.
- All pulse outputs are exactly one cycle wide. At most one error pulse fires per cycle.
- `dat`/`hdr` hold their value until the next good frame.

## Test plan
1. Good frame:
   - Stimulus: LTC2630 mode, `clk` 200 MHz, `sclk` 20 MHz, frame 0x30_8000.
   - Response: `valid` pulses once, `hdr`=0x30, `dat`=0x8000, `frame_cnt`=1, no error pulses.
2. Short frame, then recovery:
   - Stimulus: `sync_n` released after 20 bits.
   - Response: `err_len` pulses once, `dat` holds its prior value, `err_cnt`=1. The following 24-bit frame 0x30_1234 yields `dat`=0x1234.
3. Overrun:
   - Stimulus: 25 `sclk` edges inside one frame.
   - Response: `err_ovr` pulses at the 25th edge, no `valid`. The block ignores further edges until `sync_n` rises, and the next frame decodes correctly.
4. Timeout and reset during a frame:
   - Stimulus: `TIMEOUT`=100; `sync_n` held low with no `sclk` for 200 cycles.
   - Response: `err_tmo` pulses at cycle 100.
   - Separately, asserting `reset_n` after bit 10 gives zeroed outputs and no pulses, and the next full frame decodes.
5. E310V2 power-down field:
   - Stimulus: falling-edge sampling; frame 0x00_ABCD, then 0x01_ABCD.
   - Response: both give `dat`=0xABCD; `pd_err`=0, then 1.
6. Last-bit coincidence:
   - Stimulus: the 24th sample edge and the `sync_n` rise land in the same `clk` cycle.
   - Response: `valid` pulses, no `err_len`, correct `dat`.

Source files
------------

// File: rtl/dac_spi_monitor.sv
// Passive deserializer for the VCXO-trim DAC serial link.
// Oversamples sclk/mosi/sync_n, decodes 24-bit frames into hdr/dat,
// flags short, overlong and stalled frames, and never drives the bus.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_ARM   | wait for sync_n high so a frame already in flight is skipped
// ST_IDLE  | bus quiet, waiting for a sync_n falling edge
// ST_SHIFT | frame open, shifting in bits and running the stall timer
module dac_spi_monitor #(
   parameter string DEVICE      = "E200",
   parameter bit    SAMPLE_RISE = 1'b1,
   parameter int    TIMEOUT     = 4095
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        sclk,
   input  logic        mosi,
   input  logic        sync_n,
   output logic [15:0] dat,
   output logic [7:0]  hdr,
   output logic        valid,
   output logic        err_len,
   output logic        err_ovr,
   output logic        err_tmo,
   output logic        pd_err,
   output logic        busy,
   output logic [15:0] frame_cnt,
   output logic [7:0]  err_cnt
);

   localparam bit IS_AD = (DEVICE == "E310V2");
   // Down-counter loaded with TIMEOUT-1 and fired at zero, i.e. on the
   // TIMEOUT-th cycle spent in ST_SHIFT.
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {ST_ARM, ST_IDLE, ST_SHIFT} state_t;

   state_t        state_q, state_d;
   logic [2:0]    sclk_q, sclk_d;
   logic [2:0]    sync_q, sync_d;
   logic [1:0]    mosi_q, mosi_d;
   logic [1:0]    flush_q, flush_d;
   logic [23:0]   sr_q, sr_d;
   logic [4:0]    bitcnt_q, bitcnt_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [15:0]   dat_q, dat_d;
   logic [7:0]    hdr_q, hdr_d;
   logic          pd_q, pd_d;
   logic          valid_q, valid_d;
   logic          len_q, len_d;
   logic          ovr_q, ovr_d;
   logic          tmop_q, tmop_d;
   logic [15:0]   frame_cnt_q, frame_cnt_d;
   logic [7:0]    err_cnt_q, err_cnt_d;

   logic sample;
   logic sync_fall;
   logic sync_rise;

   // Edge detection on the synchronized copies plus next-state/output decode.
   always_comb begin
      sclk_d      = {sclk_q[1:0], sclk};
      sync_d      = {sync_q[1:0], sync_n};
      mosi_d      = {mosi_q[0], mosi};
      // The synchronizer reset values are not real bus history; ST_ARM
      // waits two cycles so it judges sync_n from samples of the pin.
      flush_d     = {flush_q[0], 1'b1};
      sample      = SAMPLE_RISE ? (sclk_q[1] & ~sclk_q[2]) : (~sclk_q[1] & sclk_q[2]);
      sync_fall   = ~sync_q[1] & sync_q[2];
      sync_rise   = sync_q[1] & ~sync_q[2];
      state_d     = state_q;
      sr_d        = sr_q;
      bitcnt_d    = bitcnt_q;
      tmo_d       = tmo_q;
      dat_d       = dat_q;
      hdr_d       = hdr_q;
      pd_d        = pd_q;
      valid_d     = 1'b0;
      len_d       = 1'b0;
      ovr_d       = 1'b0;
      tmop_d      = 1'b0;
      frame_cnt_d = frame_cnt_q;
      case (state_q)
         ST_ARM: begin
            if (flush_q[1] && sync_q[1]) state_d = ST_IDLE;
         end
         ST_IDLE: begin
            if (sync_fall) begin
               sr_d     = '0;
               bitcnt_d = '0;
               tmo_d    = TMO_LOAD;
               state_d  = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            // A bit arriving with the sync_n rise is counted before the length check.
            if (sample) begin
               sr_d     = {sr_q[22:0], mosi_q[1]};
               bitcnt_d = bitcnt_q + 5'd1;
            end
            if (sample && bitcnt_q == 5'd24) begin
               ovr_d   = 1'b1;
               state_d = ST_ARM;
            end else if (sync_rise) begin
               if (bitcnt_d == 5'd24) begin
                  hdr_d       = sr_d[23:16];
                  dat_d       = sr_d[15:0];
                  pd_d        = IS_AD ? (|sr_d[17:16]) : 1'b0;
                  valid_d     = 1'b1;
                  frame_cnt_d = frame_cnt_q + 16'd1;
               end else begin
                  len_d = 1'b1;
               end
               state_d = ST_IDLE;
            end else if (tmo_q == '0) begin
               tmop_d  = 1'b1;
               state_d = ST_ARM;
            end else begin
               tmo_d = tmo_q - 1'b1;
            end
         end
         default: state_d = ST_ARM;
      endcase
      err_cnt_d = err_cnt_q;
      if ((len_d || ovr_d || tmop_d) && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
   end

   // State, synchronizers and registered outputs with synchronous reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= ST_ARM;
         sclk_q      <= 3'b000;
         sync_q      <= 3'b111;
         mosi_q      <= 2'b00;
         flush_q     <= 2'b00;
         sr_q        <= '0;
         bitcnt_q    <= '0;
         tmo_q       <= '0;
         dat_q       <= '0;
         hdr_q       <= '0;
         pd_q        <= 1'b0;
         valid_q     <= 1'b0;
         len_q       <= 1'b0;
         ovr_q       <= 1'b0;
         tmop_q      <= 1'b0;
         frame_cnt_q <= '0;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         sclk_q      <= sclk_d;
         sync_q      <= sync_d;
         mosi_q      <= mosi_d;
         flush_q     <= flush_d;
         sr_q        <= sr_d;
         bitcnt_q    <= bitcnt_d;
         tmo_q       <= tmo_d;
         dat_q       <= dat_d;
         hdr_q       <= hdr_d;
         pd_q        <= pd_d;
         valid_q     <= valid_d;
         len_q       <= len_d;
         ovr_q       <= ovr_d;
         tmop_q      <= tmop_d;
         frame_cnt_q <= frame_cnt_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign dat       = dat_q;
   assign hdr       = hdr_q;
   assign pd_err    = pd_q;
   assign valid     = valid_q;
   assign err_len   = len_q;
   assign err_ovr   = ovr_q;
   assign err_tmo   = tmop_q;
   assign busy      = (state_q == ST_SHIFT);
   assign frame_cnt = frame_cnt_q;
   assign err_cnt   = err_cnt_q;

endmodule
